// File: rtl/step_dir_conditioner.sv
// rtl/step_dir_conditioner.sv - re-times raw step/dir into driver-safe step/dir pulses
// Buffers step bursts in a saturating signed accumulator and tracks absolute position.
module step_dir_conditioner #(
  parameter int DEFAULT_HIGH  = 100,
  parameter int DEFAULT_LOW   = 100,
  parameter int DEFAULT_SETUP = 50,
  parameter int PEND_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        step_in,
  input  logic        dir_in,
  output logic        step_out,
  output logic        dir_out
);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW} state_t;

  localparam logic [15:0] L_DEF_HIGH  = 16'(DEFAULT_HIGH);
  localparam logic [15:0] L_DEF_LOW   = 16'(DEFAULT_LOW);
  localparam logic [15:0] L_DEF_SETUP = 16'(DEFAULT_SETUP);
  // Two guard bits so edge + entry adjustments never wrap before clamping.
  localparam logic signed [PEND_W+1:0] L_ONE = (PEND_W+2)'(1);
  localparam logic signed [PEND_W+1:0] L_MAX = (PEND_W+2)'((2**(PEND_W-1)) - 1);
  localparam logic signed [PEND_W+1:0] L_MIN = -L_MAX;

  state_t              r_state;
  state_t              w_next;
  logic                r_step_in_d;
  logic [PEND_W-1:0]   r_pending;
  logic [31:0]         r_position;
  logic                r_overflow;
  logic [15:0]         r_cnt;
  logic [15:0]         r_step_high;
  logic [15:0]         r_step_low;
  logic [15:0]         r_dir_setup;
  logic                r_step_out;
  logic                r_dir_out;
  logic [31:0]         r_readdata;

  logic                w_edge;
  logic                w_pend_nz;
  logic                w_pend_neg;
  logic                w_req_dir;
  logic                w_cnt_done;
  logic                w_enter_high;
  logic                w_busy;
  logic                w_sat_hit;
  logic [15:0]         w_high_len;
  logic [15:0]         w_low_len;
  logic [15:0]         w_setup_len;
  logic [15:0]         w_pend_16;
  logic [31:0]         w_status;
  logic signed [PEND_W+1:0] w_pend_x;
  logic signed [PEND_W+1:0] w_inc;
  logic signed [PEND_W+1:0] w_dec;
  logic signed [PEND_W+1:0] w_sum;
  logic [PEND_W-1:0]   w_pend_next;

  assign w_edge       = step_in & ~r_step_in_d;
  assign w_pend_nz    = |r_pending;
  assign w_pend_neg   = r_pending[PEND_W-1];
  assign w_req_dir    = w_pend_nz & ~w_pend_neg;
  assign w_cnt_done   = (r_cnt <= 16'd1);
  assign w_enter_high = (w_next == STEP_HIGH) && (r_state != STEP_HIGH);
  assign w_busy       = (r_state != IDLE) || w_pend_nz;
  assign w_high_len   = (r_step_high == 16'd0) ? 16'd1 : r_step_high;
  assign w_low_len    = (r_step_low  == 16'd0) ? 16'd1 : r_step_low;
  assign w_setup_len  = (r_dir_setup == 16'd0) ? 16'd1 : r_dir_setup;
  assign w_pend_16    = 16'($signed(r_pending));
  assign w_status     = {w_pend_16, 14'd0, r_overflow, w_busy};
  assign step_out     = r_step_out;
  assign dir_out      = r_dir_out;
  assign readdata     = r_readdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_pend_nz) begin
          w_next = (r_dir_out != w_req_dir) ? DIR_SETUP : STEP_HIGH;
        end
      end
      DIR_SETUP: if (w_cnt_done) w_next = STEP_HIGH;
      STEP_HIGH: if (w_cnt_done) w_next = STEP_LOW;
      STEP_LOW:  if (w_cnt_done) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Edge and entry adjustments are summed first so a simultaneous pair nets out
  // before the clamp, and only a genuine excursion past a limit flags overflow.
  always_comb begin
    w_pend_x = {{2{r_pending[PEND_W-1]}}, r_pending};
    w_inc = '0;
    if (w_edge) w_inc = dir_in ? L_ONE : -L_ONE;
    w_dec = '0;
    if (w_enter_high && w_pend_nz) w_dec = w_pend_neg ? L_ONE : -L_ONE;
    w_sum = w_pend_x + w_inc + w_dec;
    w_pend_next = w_sum[PEND_W-1:0];
    w_sat_hit = 1'b0;
    if (w_sum > L_MAX) begin
      w_pend_next = L_MAX[PEND_W-1:0];
      w_sat_hit   = 1'b1;
    end else if (w_sum < L_MIN) begin
      w_pend_next = L_MIN[PEND_W-1:0];
      w_sat_hit   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_in_d <= 1'b0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_step_in_d <= step_in;
      r_pending   <= w_pend_next;
      if (w_sat_hit) begin
        r_overflow <= 1'b1;
      end else if (write && (address == 3'd4)) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      unique case (w_next)
        DIR_SETUP: r_cnt <= w_setup_len;
        STEP_HIGH: r_cnt <= w_high_len;
        STEP_LOW:  r_cnt <= w_low_len;
        default:   r_cnt <= '0;
      endcase
    end else if (!w_cnt_done) begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_out <= 1'b0;
      r_dir_out  <= 1'b0;
    end else begin
      r_step_out <= (w_next == STEP_HIGH);
      if ((r_state == IDLE) && (w_next == DIR_SETUP)) begin
        r_dir_out <= w_req_dir;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_position <= '0;
    end else if (write && (address == 3'd3)) begin
      r_position <= writedata;
    end else if (w_enter_high) begin
      r_position <= r_dir_out ? (r_position + 32'd1) : (r_position - 32'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_high <= L_DEF_HIGH;
      r_step_low  <= L_DEF_LOW;
      r_dir_setup <= L_DEF_SETUP;
    end else if (write) begin
      unique case (address)
        3'd0:    r_step_high <= writedata[15:0];
        3'd1:    r_step_low  <= writedata[15:0];
        3'd2:    r_dir_setup <= writedata[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_readdata <= '0;
    end else if (read) begin
      unique case (address)
        3'd0:    r_readdata <= {16'd0, r_step_high};
        3'd1:    r_readdata <= {16'd0, r_step_low};
        3'd2:    r_readdata <= {16'd0, r_dir_setup};
        3'd3:    r_readdata <= r_position;
        3'd4:    r_readdata <= w_status;
        default: r_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_conditioner.sv
// tb/tb_step_dir_conditioner.sv - directed self-checking bench for step_dir_conditioner
module tb_step_dir_conditioner;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        write, read;
  logic [31:0] readdata;
  logic        step_in, dir_in, step_out, dir_out;
  logic        write4, read4;
  logic [31:0] readdata4;
  logic        step_in4, dir_in4, step_out4, dir_out4;

  int checks = 0;
  int errors = 0;

  step_dir_conditioner u_dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .step_in(step_in), .dir_in(dir_in), .step_out(step_out), .dir_out(dir_out)
  );

  step_dir_conditioner #(.PEND_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .write(write4),
    .writedata(writedata), .read(read4), .readdata(readdata4),
    .step_in(step_in4), .dir_in(dir_in4), .step_out(step_out4), .dir_out(dir_out4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
    address = a;
    writedata = v;
    if (d == 0) write = 1'b1; else write4 = 1'b1;
    tick();
    write = 1'b0;
    write4 = 1'b0;
  endtask

  task automatic rd(input int d, input logic [2:0] a, output logic [31:0] v);
    address = a;
    if (d == 0) read = 1'b1; else read4 = 1'b1;
    tick();
    read = 1'b0;
    read4 = 1'b0;
    v = (d == 0) ? readdata : readdata4;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_regs [5];
    exp_regs = '{32'd100, 32'd100, 32'd50, 32'd0, 32'd0};
    checks++;
    if (step_out !== 1'b0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: step_out=%b dir_out=%b required 0/0", step_out, dir_out);
    end
    checks++;
    if (readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_readdata: got %h required 0", readdata);
    end
    for (int i = 0; i < 5; i++) begin
      rd(0, 3'(i), v);
      checks++;
      if (v !== exp_regs[i]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %0d required %0d", i, v, exp_regs[i]);
      end
    end
    wr(0, 3'd5, 32'hdeadbeef);
    rd(0, 3'd5, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL unused_addr5: got %h required 0", v);
    end
  endtask

  task automatic test_single_step();
    logic [31:0] v;
    logic exp_step, exp_dir;
    wr(0, 3'd0, 32'd3);
    wr(0, 3'd1, 32'd2);
    wr(0, 3'd2, 32'd4);
    step_in = 1'b1;
    dir_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) step_in = 1'b0;
      exp_step = (k >= 6 && k <= 8);
      exp_dir = (k >= 2);
      checks++;
      if (step_out !== exp_step) begin
        errors++;
        $display("FAIL single_step_out N+%0d: got %b required %b", k, step_out, exp_step);
      end
      checks++;
      if (dir_out !== exp_dir) begin
        errors++;
        $display("FAIL single_dir_out N+%0d: got %b required %b", k, dir_out, exp_dir);
      end
      if (k == 11) begin
        checks++;
        if (readdata[0] !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_N+10: got %b required 1", readdata[0]);
        end
      end
      if (k == 12) begin
        checks++;
        if (readdata !== 32'd0) begin
          errors++;
          $display("FAIL single_status_N+11: got %h required 0", readdata);
        end
      end
      address = 3'd4;
      read = (k == 10 || k == 11);
    end
    read = 1'b0;
    rd(0, 3'd3, v);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL single_position: got %0d required 1", v);
    end
  endtask

  task automatic test_burst();
    logic [31:0] v;
    int pulses, hi, lo, bad_high, bad_low;
    logic prev;
    pulses = 0; hi = 0; lo = 0; bad_high = 0; bad_low = 0; prev = 1'b0;
    wr(0, 3'd3, 32'd0);
    for (int k = 0; k < 120; k++) begin
      step_in = (k < 20) && (k % 2 == 0);
      dir_in = 1'b1;
      tick();
      if (step_out) begin
        if (!prev) begin
          if (pulses > 0 && lo < 2) bad_low++;
          pulses++;
          lo = 0;
        end
        hi++;
      end else begin
        if (prev) begin
          if (hi != 3) bad_high++;
          hi = 0;
        end
        lo++;
      end
      prev = step_out;
    end
    checks++;
    if (pulses != 10) begin
      errors++;
      $display("FAIL burst_pulses: got %0d required 10", pulses);
    end
    checks++;
    if (bad_high != 0) begin
      errors++;
      $display("FAIL burst_high_width: %0d pulses not 3 cycles high, required 0", bad_high);
    end
    checks++;
    if (bad_low != 0) begin
      errors++;
      $display("FAIL burst_low_width: %0d gaps under 2 cycles, required 0", bad_low);
    end
    rd(0, 3'd3, v);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL burst_position: got %0d required 10", v);
    end
    rd(0, 3'd4, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL burst_status: got %h required 0 (pending 0, idle)", v);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] v;
    int pulses, dir_low;
    logic prev;
    pulses = 0; dir_low = 0; prev = 1'b0;
    wr(0, 3'd0, 32'd100);
    wr(0, 3'd3, 32'd0);
    for (int k = 0; k < 300; k++) begin
      step_in = (k < 16) && (k % 2 == 0);
      dir_in = (k < 10);
      tick();
      if (step_out && !prev) pulses++;
      if (dir_out !== 1'b1) dir_low++;
      prev = step_out;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL cancel_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (dir_low != 0) begin
      errors++;
      $display("FAIL cancel_dir_hold: dir_out low for %0d cycles, required 0", dir_low);
    end
    rd(0, 3'd3, v);
    checks++;
    if (v !== 32'd2) begin
      errors++;
      $display("FAIL cancel_position: got %0d required 2", v);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int budget;
    wr(1, 3'd0, 32'd100);
    wr(1, 3'd2, 32'd0);
    for (int k = 0; k < 26; k++) begin
      step_in4 = (k < 24) && (k % 2 == 0);
      dir_in4 = 1'b1;
      tick();
    end
    rd(1, 3'd4, v);
    checks++;
    if (v[31:16] !== 16'd7) begin
      errors++;
      $display("FAIL ovf_pending: got %0d required 7", v[31:16]);
    end
    checks++;
    if (v[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag_set: got %b required 1", v[1]);
    end
    wr(1, 3'd4, 32'd0);
    rd(1, 3'd4, v);
    checks++;
    if (v[1] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_flag_clear: got %b required 0", v[1]);
    end
    budget = 3000;
    v = 32'd1;
    while (v[0] !== 1'b0 && budget > 0) begin
      rd(1, 3'd4, v);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL ovf_drain_timeout: busy=%b after 3000 cycles, required 0", v[0]);
    end
    rd(1, 3'd3, v);
    checks++;
    if (v !== 32'd8) begin
      errors++;
      $display("FAIL ovf_position: got %0d required 8", v);
    end
  endtask

  task automatic test_reverse();
    logic [31:0] v;
    int fall_k, rise_k;
    fall_k = -1; rise_k = -1;
    wr(0, 3'd0, 32'd3);
    wr(0, 3'd3, 32'd3);
    step_in = 1'b1;
    dir_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      step_in = 1'b0;
      if (fall_k < 0 && dir_out === 1'b0) fall_k = k;
      if (rise_k < 0 && step_out === 1'b1) rise_k = k;
    end
    checks++;
    if (fall_k != 2) begin
      errors++;
      $display("FAIL reverse_dir_fall: at N+%0d required N+2", fall_k);
    end
    checks++;
    if (rise_k != 6) begin
      errors++;
      $display("FAIL reverse_step_rise: at N+%0d required N+6", rise_k);
    end
    rd(0, 3'd3, v);
    checks++;
    if (v !== 32'd2) begin
      errors++;
      $display("FAIL reverse_position: got %0d required 2", v);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    logic [31:0] exp_regs [5];
    exp_regs = '{32'd100, 32'd100, 32'd50, 32'd0, 32'd0};
    wr(0, 3'd0, 32'd100);
    step_in = 1'b1;
    dir_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      step_in = 1'b0;
    end
    checks++;
    if (step_out !== 1'b1 || dir_out !== 1'b1) begin
      errors++;
      $display("FAIL midpulse_pre: step_out=%b dir_out=%b required 1/1", step_out, dir_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (step_out !== 1'b0 || dir_out !== 1'b0) begin
      errors++;
      $display("FAIL midpulse_async: step_out=%b dir_out=%b required 0/0", step_out, dir_out);
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      rd(0, 3'(i), v);
      checks++;
      if (v !== exp_regs[i]) begin
        errors++;
        $display("FAIL midpulse_reg%0d: got %0d required %0d", i, v, exp_regs[i]);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    address = '0;
    writedata = '0;
    write = 1'b0;
    read = 1'b0;
    step_in = 1'b0;
    dir_in = 1'b0;
    write4 = 1'b0;
    read4 = 1'b0;
    step_in4 = 1'b0;
    dir_in4 = 1'b0;
    #22 reset = 1'b1;
    tick();
    test_reset();
    test_single_step();
    test_burst();
    test_cancel();
    test_overflow();
    test_reverse();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_dir_conditioner.md
Name: step_dir_conditioner

Overview:
- Sits directly downstream of the Stepper block and consumes its raw step/dir outputs.
- Re-times them into a step/dir pair that meets external driver timing: direction setup before the step edge, minimum step high width, and minimum step low width.
- Buffers bursts in a signed pending-step accumulator and tracks absolute position.
- Timing registers and status are exposed over the same Avalon-MM slave style as Stepper.

Parameters:
- DEFAULT_HIGH, 100: reset value of step-high width, in clk cycles.
- DEFAULT_LOW, 100: reset value of step-low width, in clk cycles.
- DEFAULT_SETUP, 50: reset value of dir-to-step setup time, in clk cycles.
- PEND_W, 16: width of the signed pending accumulator; saturates at ±(2^(PEND_W-1)-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- write  in  1  register write strobe.
- writedata  in  32  write data.
- read  in  1  register read strobe.
- readdata  out  32  read data, registered.
- step_in  in  1  raw step from Stepper, same clock domain.
- dir_in  in  1  raw direction from Stepper; 1 = forward.
- step_out  out  1  conditioned step to driver; registered.
- dir_out  out  1  conditioned direction to driver; registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - step_out=0, dir_out=0, readdata=0, pending=0, position=0, overflow=0, state=IDLE.
  - Timing registers load their DEFAULT_* values.
  - Reset asserted mid-pulse aborts the pulse immediately.
- Edge detect: register step_in_d; edge = step_in & ~step_in_d. dir_in is sampled in the same cycle as the edge.
- Pending update at the next clock edge:
  - +1 if the sampled dir is 1, −1 if it is 0.
  - On entry to STEP_HIGH, pending moves one step toward 0.
  - An edge and an entry decrement in the same cycle both apply, giving the net value.
  - Saturate at the limits; any attempt to exceed a limit sets sticky overflow.
- FSM states: IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW.
  - IDLE, pending≠0: required dir = (pending>0).
    - If dir_out≠required: set dir_out, go to DIR_SETUP.
    - Otherwise go directly to STEP_HIGH.
  - DIR_SETUP: hold for setup cycles, then STEP_HIGH.
  - STEP_HIGH: step_out=1 for high cycles.
    - On entry: position += 1 if dir_out=1, else position −= 1; pending is decremented toward 0.
    - Then go to STEP_LOW.
  - STEP_LOW: step_out=0 for low cycles, then IDLE. This also serves as the dir hold time.
- Latency: with no dir change, step_out rises 2 cycles after the cycle in which the edge is detected.
- Phase durations:
  - Each phase counter loads the current register value at phase entry; a value of 0 is treated as 1.
  - A register write mid-phase takes effect at the next phase entry.
- Register map:
  - 0: step_high, 16b, R/W.
  - 1: step_low, 16b, R/W.
  - 2: dir_setup, 16b, R/W.
  - 3: position, 32b signed, R/W. A write has priority over a same-cycle step update.
  - 4: status, R.
    - bit0 busy (state≠IDLE or pending≠0).
    - bit1 overflow.
    - bits31:16 pending, sign-extended or truncated to 16b.
    - Any write to address 4 clears overflow. If a saturation hit occurs in the same cycle, the set wins.
  - 5–7: read 0, writes ignored.
- readdata: updated on the clock edge where read=1; holds its value otherwise.
- Unknown dir behaviour: none. dir_out changes only on the IDLE→DIR_SETUP transition.

Test Plan:
1. Single forward step: high=3, low=2, setup=4; one dir=1 edge detected at cycle N.
   - Required: dir_out=1 at N+2; step_out=1 for N+6..N+8; IDLE at N+11; position=1; status busy=0.
2. Burst: 10 dir=1 edges, one every 2 cycles, same config.
   - Required: exactly 10 step_out pulses, each 3 cycles high and ≥2 cycles low; position=10; pending=0.
3. Cancel: high=100; 5 dir=1 edges, then 3 dir=0 edges within 20 cycles.
   - Required: exactly 2 pulses; dir_out stays 1; position=2.
4. Overflow: PEND_W=4, high=100; 12 dir=1 edges.
   - Required: pending reads 7 and status bit1=1; a write to address 4 clears bit1; the run finishes with position=8.
5. Reverse after idle: position=3, dir_out=1; one dir=0 edge with setup=4.
   - Required: dir_out=0 at least 4 cycles before step_out rises; position=2.
6. Reset mid-pulse: drive reset=0 during STEP_HIGH.
   - Required: step_out=0 and dir_out=0 in the same cycle, with no clock needed; after release, registers read 100/100/50, position=0, status=0.
